// File: rtl/prom_load_sequencer.sv
// Sequences downloader bytes into up to four PROM regions with a setup/strobe/hold
// write cycle, a one-entry skid buffer, session byte count and sticky error flags.
module prom_load_sequencer #(
    parameter logic [21:0] R0_BASE = 22'h000000,
    parameter logic [21:0] R1_BASE = 22'h010000,
    parameter logic [21:0] R2_BASE = 22'h020000,
    parameter logic [21:0] R3_BASE = 22'h030000,
    parameter int          R0_AW   = 16,
    parameter int          R1_AW   = 16,
    parameter int          R2_AW   = 16,
    parameter int          R3_AW   = 16
) (
    input  logic        i_EMU_PROG_CLK,
    input  logic        i_RST,
    input  logic        i_DL_ACTIVE,
    input  logic        i_DL_WR,
    input  logic [21:0] i_DL_ADDR,
    input  logic [7:0]  i_DL_DATA,
    output logic        o_DL_WAIT,
    output logic [15:0] o_PROG_ADDR,
    output logic [7:0]  o_PROG_DIN,
    output logic [3:0]  o_PROG_CS_n,
    output logic        o_PROG_WR_n,
    output logic [21:0] o_BYTE_CNT,
    output logic        o_LOAD_DONE,
    output logic [1:0]  o_ERR
);

    // state  | meaning
    // IDLE   | no write in flight; accepts skid byte first, then live strobe
    // SETUP  | CS low, WR high, address/data settling
    // STROBE | CS low, WR low (the single write pulse)
    // HOLD   | CS low, WR high, byte counted
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t      state, state_nxt;
    logic        active_q, wait_q, load_done, skid_vld, skid_vld_nxt;
    logic [21:0] skid_addr, pend_addr, byte_cnt, cnt_base;
    logic [7:0]  skid_data, pend_data, din_q;
    logic [15:0] addr_q, pend_off;
    logic [1:0]  region_q, hit_idx, err;
    logic [3:0]  hit, cs_n;
    logic        wr_n, idle, wr_live, start, pend, mapped;
    logic        take_skid, skid_load, skid_drop, unmapped, accept;

    function automatic logic in_region(input logic [21:0] a, input logic [21:0] base,
                                       input int aw);
        logic [22:0] lo, hi;
        lo = {1'b0, base};
        hi = lo + (23'd1 << aw);
        return ({1'b0, a} >= lo) && ({1'b0, a} < hi);
    endfunction

    always_comb begin
        idle      = (state == IDLE);
        wr_live   = i_DL_WR & i_DL_ACTIVE;
        start     = i_DL_ACTIVE & ~active_q;
        pend      = idle & (skid_vld | wr_live);
        pend_addr = skid_vld ? skid_addr : i_DL_ADDR;
        pend_data = skid_vld ? skid_data : i_DL_DATA;
        hit       = {in_region(pend_addr, R3_BASE, R3_AW), in_region(pend_addr, R2_BASE, R2_AW),
                     in_region(pend_addr, R1_BASE, R1_AW), in_region(pend_addr, R0_BASE, R0_AW)};
        mapped    = |hit;
        hit_idx   = 2'd0;
        pend_off  = 16'd0;
        // Lowest region wins; offsets fit in 16 bits since every span is at most 64 KiB.
        if (hit[0]) begin
            hit_idx  = 2'd0;
            pend_off = pend_addr[15:0] - R0_BASE[15:0];
        end else if (hit[1]) begin
            hit_idx  = 2'd1;
            pend_off = pend_addr[15:0] - R1_BASE[15:0];
        end else if (hit[2]) begin
            hit_idx  = 2'd2;
            pend_off = pend_addr[15:0] - R2_BASE[15:0];
        end else if (hit[3]) begin
            hit_idx  = 2'd3;
            pend_off = pend_addr[15:0] - R3_BASE[15:0];
        end
        accept       = pend & mapped;
        unmapped     = pend & ~mapped;
        take_skid    = idle & skid_vld;
        // In IDLE an occupied buffer drains this cycle, so a new strobe may refill it.
        skid_load    = wr_live & (idle ? skid_vld : ~skid_vld);
        skid_drop    = wr_live & ~idle & skid_vld;
        skid_vld_nxt = skid_load | (skid_vld & ~take_skid);
        cnt_base     = start ? 22'd0 : byte_cnt;
    end

    always_ff @(posedge i_EMU_PROG_CLK or posedge i_RST) begin
        if (i_RST) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cs_n      = 4'b1111;
        wr_n      = 1'b1;
        case (state)
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   state_nxt = STROBE;
            STROBE:  state_nxt = HOLD;
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (state != IDLE)   cs_n[region_q] = 1'b0;
        if (state == STROBE) wr_n = 1'b0;
    end

    always_ff @(posedge i_EMU_PROG_CLK or posedge i_RST) begin
        if (i_RST) begin
            active_q  <= 1'b0;
            wait_q    <= 1'b0;
            load_done <= 1'b0;
            skid_vld  <= 1'b0;
            skid_addr <= 22'd0;
            skid_data <= 8'd0;
            addr_q    <= 16'd0;
            din_q     <= 8'd0;
            region_q  <= 2'd0;
            err       <= 2'b00;
            byte_cnt  <= 22'd0;
        end else begin
            active_q <= i_DL_ACTIVE;
            if (accept) begin
                addr_q   <= pend_off;
                din_q    <= pend_data;
                region_q <= hit_idx;
            end
            if (skid_load) begin
                skid_addr <= i_DL_ADDR;
                skid_data <= i_DL_DATA;
            end
            skid_vld  <= skid_vld_nxt;
            wait_q    <= (state_nxt != IDLE) | skid_vld_nxt;
            err       <= (start ? 2'b00 : err) | {skid_drop, unmapped};
            load_done <= ~start & (load_done | (~i_DL_ACTIVE & idle & ~skid_vld));
            if (state == HOLD && cnt_base != {22{1'b1}}) byte_cnt <= cnt_base + 22'd1;
            else                                         byte_cnt <= cnt_base;
        end
    end

    assign o_DL_WAIT   = wait_q;
    assign o_PROG_ADDR = addr_q;
    assign o_PROG_DIN  = din_q;
    assign o_PROG_CS_n = cs_n;
    assign o_PROG_WR_n = wr_n;
    assign o_BYTE_CNT  = byte_cnt;
    assign o_LOAD_DONE = load_done;
    assign o_ERR       = err;

endmodule

// File: doc/prom_load_sequencer.md
PROM_LOAD_SEQUENCER -- requirements
Module: prom_load_sequencer

Interface
REQ-001 SHALL have parameters (name, default, meaning): R0_BASE, 22'h000000, region 0 byte base.
REQ-002 SHALL have parameter R1_BASE, 22'h010000, region 1 byte base; R2_BASE, 22'h020000; R3_BASE, 22'h030000 likewise.
REQ-003 SHALL have parameters R0_AW..R3_AW, 16, region k spans 2**Rk_AW bytes; each Rk_AW is at most 16.
REQ-004 SHALL use one clock and an asynchronous, active-high reset; no other clock domain.
REQ-005 Ports (name, direction, width, meaning), one per line:
  i_EMU_PROG_CLK  in  1  sole clock, rising edge.
  i_RST  in  1  async reset, active high.
  i_DL_ACTIVE  in  1  download session in progress.
  i_DL_WR  in  1  one-cycle byte strobe.
  i_DL_ADDR  in  22  absolute byte address.
  i_DL_DATA  in  8  byte value.
  o_DL_WAIT  out  1  back-pressure to the downloader.
  o_PROG_ADDR  out  16  region-relative address to the PROMs.
  o_PROG_DIN  out  8  write data to the PROMs.
  o_PROG_CS_n  out  4  per-region chip select, active low.
  o_PROG_WR_n  out  1  shared write strobe, active low.
  o_BYTE_CNT  out  22  bytes written in the current session.
  o_LOAD_DONE  out  1  session complete, PROMs readable.
  o_ERR  out  2  sticky errors: bit0 unmapped address, bit1 overflow.

Function
REQ-006 Decode: a byte hits region k iff Rk_BASE <= addr < Rk_BASE + 2**Rk_AW; the lowest k wins on overlap.
REQ-007 o_PROG_ADDR SHALL be addr - Rk_BASE, zero-extended to 16 bits.
REQ-008 FSM states: IDLE, SETUP, STROBE, HOLD; each non-IDLE state lasts exactly 1 cycle.
REQ-009 IDLE: with a pending byte (skid buffer first, else the live i_DL_WR), SHALL latch addr/data; a mapped byte goes to SETUP; an unmapped byte sets o_ERR[0], is dropped and stays in IDLE.
REQ-010 SETUP: o_PROG_CS_n[k]=0, o_PROG_WR_n=1; ADDR/DIN valid and stable.
REQ-011 STROBE: o_PROG_CS_n[k]=0, o_PROG_WR_n=0; ADDR/DIN unchanged.
REQ-012 HOLD: o_PROG_CS_n[k]=0, o_PROG_WR_n=1; o_BYTE_CNT increments; next state is IDLE.
REQ-013 Each mapped byte SHALL produce exactly one WR_n-low cycle; throughput is one byte per 4 cycles.
REQ-014 Outside SETUP/STROBE/HOLD, o_PROG_CS_n SHALL be 4'b1111 and o_PROG_WR_n SHALL be 1.
REQ-015 At most one CS_n bit SHALL be low at any time.
REQ-016 Skid buffer: one entry, loaded by i_DL_WR when the FSM is not in IDLE or the buffer is occupied by an earlier byte.
REQ-017 An i_DL_WR arriving while the buffer is full SHALL be dropped and SHALL set o_ERR[1].
REQ-018 o_DL_WAIT = (FSM != IDLE) OR buffer occupied, registered.
REQ-019 Rising edge of i_DL_ACTIVE SHALL clear o_BYTE_CNT, o_ERR and o_LOAD_DONE; an i_DL_WR in the same cycle is still accepted.
REQ-020 o_LOAD_DONE SHALL set one cycle after i_DL_ACTIVE=0, FSM in IDLE and buffer empty, then hold until the next session start.
REQ-021 i_DL_WR while i_DL_ACTIVE=0 SHALL be ignored.
REQ-022 o_BYTE_CNT SHALL saturate at all-ones and not wrap.

Reset
REQ-023 While i_RST=1, outputs SHALL be: CS_n=4'b1111, WR_n=1, WAIT=0, BYTE_CNT=0, ERR=0, LOAD_DONE=0, PROG_ADDR=0, PROG_DIN=0.
REQ-024 While i_RST=1, the FSM SHALL be in IDLE and the buffer empty.
REQ-025 Reset asserted mid-write SHALL abort the write immediately (WR_n high asynchronously); the byte is lost.

Verification
REQ-026 Default parameters; ACTIVE=1; WR at addr 0x010005, data 0xA5 -> SETUP/STROBE/HOLD on CS_n=4'b1101, ADDR=0x0005, DIN=0xA5, one WR_n-low cycle; BYTE_CNT=1.
REQ-027 Strobes at addr 0x000000 on cycles t and t+1 -> second byte buffered, WAIT high; two writes complete by t+8; ERR=0.
REQ-028 Strobes on cycles t, t+1, t+2 -> third byte dropped; ERR=2'b10; exactly two WR_n pulses.
REQ-029 WR at 0x3FFFFF -> no CS_n activity; ERR=2'b01; BYTE_CNT unchanged.
REQ-030 Drop ACTIVE after the final byte -> LOAD_DONE rises 1 cycle after HOLD; re-raising ACTIVE clears LOAD_DONE, BYTE_CNT and ERR.
REQ-031 i_RST pulsed during STROBE -> WR_n=1 and CS_n=4'b1111 in the same cycle; all outputs at reset values.
